// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit FSM with valid/ready byte intake and optional parity
// Define UART_TX_FSM_TMR_EN to triplicate state, bit counter and shift register with majority voting.
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  BitTick_i,
    input  logic [DATA_WIDTH-1:0] TxData_i,
    input  logic                  TxDataValid_i,
    output logic                  TxReady_o,
    input  logic                  p_ParityEnable_i,
    input  logic                  p_ParityOdd_i,
    output logic                  TxWire_o,
    output logic [4:0]            State_o,
    output logic [CNT_WIDTH-1:0]  BitCounter_o,
    output logic                  TxBusy_o,
    output logic                  TxDone_o
);

    // One-hot encoding shared with the Rx core so status logic can decode both.
    typedef enum logic [4:0] {
        S_INTERVAL  = 5'b0_0001,
        S_STARTBIT  = 5'b0_0010,
        S_DATABITS  = 5'b0_0100,
        S_PARITYBIT = 5'b0_1000,
        S_STOPBIT   = 5'b1_0000
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state_v;
    state_t                  state_nx;
    logic [CNT_WIDTH-1:0]    cnt_v;
    logic [CNT_WIDTH-1:0]    cnt_nx;
    logic [DATA_WIDTH-1:0]   shift_v;
    logic [DATA_WIDTH-1:0]   shift_nx;

    logic                    pending_r;
    logic [DATA_WIDTH-1:0]   hold_r;
    logic                    par_bit_r;
    logic                    par_en_r;
    logic                    wire_r;
    logic                    done_r;

    logic                    wire_nx;
    logic                    done_nx;
    logic                    load;

`ifdef UART_TX_FSM_TMR_EN
    (* preserve *) logic [4:0]            state_a_r;
    (* preserve *) logic [4:0]            state_b_r;
    (* preserve *) logic [4:0]            state_c_r;
    (* preserve *) logic [CNT_WIDTH-1:0]  cnt_a_r;
    (* preserve *) logic [CNT_WIDTH-1:0]  cnt_b_r;
    (* preserve *) logic [CNT_WIDTH-1:0]  cnt_c_r;
    (* preserve *) logic [DATA_WIDTH-1:0] shift_a_r;
    (* preserve *) logic [DATA_WIDTH-1:0] shift_b_r;
    (* preserve *) logic [DATA_WIDTH-1:0] shift_c_r;

    assign state_v = state_t'((state_a_r & state_b_r) | (state_b_r & state_c_r) | (state_c_r & state_a_r));
    assign cnt_v   = (cnt_a_r & cnt_b_r) | (cnt_b_r & cnt_c_r) | (cnt_c_r & cnt_a_r);
    assign shift_v = (shift_a_r & shift_b_r) | (shift_b_r & shift_c_r) | (shift_c_r & shift_a_r);

    // Every copy reloads from the voted next value, scrubbing a single upset in one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_a_r <= S_INTERVAL;
            state_b_r <= S_INTERVAL;
            state_c_r <= S_INTERVAL;
            cnt_a_r   <= '0;
            cnt_b_r   <= '0;
            cnt_c_r   <= '0;
            shift_a_r <= '0;
            shift_b_r <= '0;
            shift_c_r <= '0;
        end else begin
            state_a_r <= state_nx;
            state_b_r <= state_nx;
            state_c_r <= state_nx;
            cnt_a_r   <= cnt_nx;
            cnt_b_r   <= cnt_nx;
            cnt_c_r   <= cnt_nx;
            shift_a_r <= shift_nx;
            shift_b_r <= shift_nx;
            shift_c_r <= shift_nx;
        end
    end
`else
    state_t                state_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;

    assign state_v = state_r;
    assign cnt_v   = cnt_r;
    assign shift_v = shift_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_INTERVAL;
            cnt_r   <= '0;
            shift_r <= '0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            shift_r <= shift_nx;
        end
    end
`endif

    // Next state and next line level; the line register follows the state being entered.
    always_comb begin
        state_nx = state_v;
        cnt_nx   = cnt_v;
        shift_nx = shift_v;
        wire_nx  = 1'b1;
        done_nx  = 1'b0;
        load     = 1'b0;
        case (state_v)
            S_INTERVAL: begin
                cnt_nx  = '0;
                wire_nx = 1'b1;
                if (BitTick_i && pending_r) begin
                    state_nx = S_STARTBIT;
                    shift_nx = hold_r;
                    load     = 1'b1;
                    wire_nx  = 1'b0;
                end
            end
            S_STARTBIT: begin
                wire_nx = 1'b0;
                if (BitTick_i) begin
                    state_nx = S_DATABITS;
                    cnt_nx   = '0;
                    wire_nx  = shift_v[0];
                end
            end
            S_DATABITS: begin
                wire_nx = shift_v[0];
                if (BitTick_i) begin
                    if (cnt_v == LAST_BIT) begin
                        cnt_nx = '0;
                        if (par_en_r) begin
                            state_nx = S_PARITYBIT;
                            wire_nx  = par_bit_r;
                        end else begin
                            state_nx = S_STOPBIT;
                            wire_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx   = cnt_v + CNT_WIDTH'(1);
                        shift_nx = shift_v >> 1;
                        wire_nx  = shift_v[1];
                    end
                end
            end
            S_PARITYBIT: begin
                cnt_nx  = '0;
                wire_nx = par_bit_r;
                if (BitTick_i) begin
                    state_nx = S_STOPBIT;
                    wire_nx  = 1'b1;
                end
            end
            S_STOPBIT: begin
                cnt_nx  = '0;
                wire_nx = 1'b1;
                if (BitTick_i) begin
                    state_nx = S_INTERVAL;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_INTERVAL;
                cnt_nx   = '0;
                shift_nx = '0;
                wire_nx  = 1'b1;
            end
        endcase
    end

    // Holding register, parity snapshot and registered line/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 1'b0;
            hold_r    <= '0;
            par_bit_r <= 1'b0;
            par_en_r  <= 1'b0;
            wire_r    <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            wire_r <= wire_nx;
            done_r <= done_nx;
            if (load) begin
                pending_r <= 1'b0;
                par_bit_r <= p_ParityOdd_i ? ~^hold_r : ^hold_r;
                par_en_r  <= p_ParityEnable_i;
            end else if (TxDataValid_i && !pending_r) begin
                pending_r <= 1'b1;
                hold_r    <= TxData_i;
            end
        end
    end

    assign TxReady_o    = ~pending_r;
    assign TxWire_o     = wire_r;
    assign State_o      = state_v;
    assign BitCounter_o = cnt_v;
    assign TxBusy_o     = (state_v != S_INTERVAL);
    assign TxDone_o     = done_r;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - self-checking bench for uart_tx_fsm against a frame-level reference model
module tb_uart_tx_fsm;

    localparam int TICK_GAP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BitTick_i = 1'b0;
    logic [7:0] TxData_i = 8'h00;
    logic       TxDataValid_i = 1'b0;
    logic       TxReady_o;
    logic       p_ParityEnable_i = 1'b0;
    logic       p_ParityOdd_i = 1'b0;
    logic       TxWire_o;
    logic [4:0] State_o;
    logic [3:0] BitCounter_o;
    logic       TxBusy_o;
    logic       TxDone_o;

    int checks = 0;
    int errors = 0;

    uart_tx_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .BitTick_i        (BitTick_i),
        .TxData_i         (TxData_i),
        .TxDataValid_i    (TxDataValid_i),
        .TxReady_o        (TxReady_o),
        .p_ParityEnable_i (p_ParityEnable_i),
        .p_ParityOdd_i    (p_ParityOdd_i),
        .TxWire_o         (TxWire_o),
        .State_o          (State_o),
        .BitCounter_o     (BitCounter_o),
        .TxBusy_o         (TxBusy_o),
        .TxDone_o         (TxDone_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        repeat (TICK_GAP - 1) @(negedge clk);
        BitTick_i = 1'b1;
        @(negedge clk);
        BitTick_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        while (TxReady_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", TxReady_o, 1);
        TxData_i      = b;
        TxDataValid_i = 1'b1;
        @(negedge clk);
        TxDataValid_i = 1'b0;
        TxData_i      = 8'($urandom);
        chk("ready_low_after_accept", TxReady_o, 0);
    endtask

    // Reference: a frame is start 0, data LSB first, optional parity, stop 1.
    // mode 1 queues nb after the start bit; mode 2 flips the parity config mid-frame.
    task automatic run_frame(input logic [7:0] b, input logic pen, input logic podd,
                             input int mode, input logic [7:0] nb);
        logic bits[$];
        logic [4:0] want_state;
        int last;
        p_ParityEnable_i = pen;
        p_ParityOdd_i    = podd;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (pen) bits.push_back(podd ? ~(^b) : ^b);
        bits.push_back(1'b1);
        last = bits.size() - 1;
        for (int i = 0; i <= last; i++) begin
            tick();
            if (i == 0)         want_state = 5'b0_0010;
            else if (i <= 8)    want_state = 5'b0_0100;
            else if (i == last) want_state = 5'b1_0000;
            else                want_state = 5'b0_1000;
            chk($sformatf("wire_%02h_bit%0d", b, i), TxWire_o, bits[i]);
            chk($sformatf("state_%02h_bit%0d", b, i), State_o, want_state);
            if (i >= 1 && i <= 8) chk($sformatf("cnt_%02h_bit%0d", b, i), BitCounter_o, i - 1);
            else                  chk($sformatf("cnt_zero_%02h_bit%0d", b, i), BitCounter_o, 0);
            if (i == 0) begin
                chk("ready_at_start", TxReady_o, 1);
                chk("busy_in_frame", TxBusy_o, 1);
                if (mode == 1) push(nb);
            end
            if (i == 3 && mode == 2) begin
                p_ParityEnable_i = ~pen;
                p_ParityOdd_i    = ~podd;
            end
            if (i == 5) begin
                repeat (3) @(negedge clk);
                chk("hold_wire_no_tick", TxWire_o, bits[i]);
                chk("hold_state_no_tick", State_o, want_state);
            end
        end
        tick();
        chk("wire_after_stop", TxWire_o, 1);
        chk("state_after_stop", State_o, 5'b0_0001);
        chk("busy_after_stop", TxBusy_o, 0);
        chk("done_pulse", TxDone_o, 1);
        @(negedge clk);
        chk("done_one_cycle", TxDone_o, 0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rpen;
        logic       rpodd;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_wire", TxWire_o, 1);
        chk("rst_state", State_o, 5'b0_0001);
        chk("rst_ready", TxReady_o, 1);
        chk("rst_busy", TxBusy_o, 0);
        chk("rst_done", TxDone_o, 0);
        chk("rst_cnt", BitCounter_o, 0);

        // 0x55 no parity: alternating pattern on the line.
        push(8'h55);
        run_frame(8'h55, 1'b0, 1'b0, 0, 8'h00);

        // 0x80 with even then odd parity.
        push(8'h80);
        run_frame(8'h80, 1'b1, 1'b0, 0, 8'h00);
        push(8'h80);
        run_frame(8'h80, 1'b1, 1'b1, 0, 8'h00);

        // Back-to-back: second byte queued during the first frame, one idle tick between.
        push(8'hA5);
        run_frame(8'hA5, 1'b0, 1'b0, 1, 8'h3C);
        run_frame(8'h3C, 1'b0, 1'b0, 0, 8'h00);

        // Mid-frame config change is ignored in both directions.
        push(8'hC3);
        run_frame(8'hC3, 1'b1, 1'b0, 2, 8'h00);
        push(8'h17);
        run_frame(8'h17, 1'b0, 1'b1, 2, 8'h00);
        p_ParityEnable_i = 1'b0;
        p_ParityOdd_i    = 1'b0;

        // Accept on the same edge as an idle tick: no start until the following tick.
        tick();
        TxData_i      = 8'h6E;
        TxDataValid_i = 1'b1;
        BitTick_i     = 1'b1;
        @(negedge clk);
        TxDataValid_i = 1'b0;
        BitTick_i     = 1'b0;
        chk("accept_tick_state", State_o, 5'b0_0001);
        chk("accept_tick_ready", TxReady_o, 0);
        chk("accept_tick_wire", TxWire_o, 1);
        run_frame(8'h6E, 1'b1, 1'b1, 0, 8'h00);

        // Reset mid-frame with a byte pending: line high at once, pending byte dropped.
        push(8'h96);
        tick();
        tick();
        push(8'h11);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wire_immediate", TxWire_o, 1);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", State_o, 5'b0_0001);
        chk("midrst_ready", TxReady_o, 1);
        chk("midrst_busy", TxBusy_o, 0);
        chk("midrst_cnt", BitCounter_o, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_idle_wire", TxWire_o, 1);
            chk("midrst_idle_state", State_o, 5'b0_0001);
        end

        // Randomized frames against the reference.
        for (int k = 0; k < 8; k++) begin
            rb    = 8'($urandom);
            rpen  = 1'($urandom_range(0, 1));
            rpodd = 1'($urandom_range(0, 1));
            push(rb);
            run_frame(rb, rpen, rpodd, (k % 3 == 0) ? 2 : 0, 8'h00);
        end

`ifdef UART_TX_FSM_TMR_EN
        // Single-copy upset in idle is outvoted and scrubbed on the next clock.
        @(negedge clk);
        force dut.state_b_r = 5'b0_0100;
        @(negedge clk);
        chk("tmr_state_voted", State_o, 5'b0_0001);
        chk("tmr_wire", TxWire_o, 1);
        release dut.state_b_r;
        @(negedge clk);
        chk("tmr_scrubbed", dut.state_b_r, dut.state_a_r);
        chk("tmr_state_after", State_o, 5'b0_0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
